// File: rtl/ha_array_accumulator.sv
// ha_array_accumulator
// Final-summation stage behind the half-adder array front end of the
// approximate 8x8 multiplier. It captures the four carry/sum row pairs,
// weights them by position and accumulates them into an 18-bit sum over
// 4/ROWS_PER_CYCLE cycles. The low OUT_W bits are presented on p, and any
// higher bits are flagged on ovf. The block uses a valid/ready handshake on
// both sides.
// Optional feature: define ERR_MON_EN to add an exact x*y reference, a signed
// error output and a sticky maximum absolute error.
module ha_array_accumulator #(
  parameter int ROWS_PER_CYCLE = 1,
  parameter int OUT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       ha_array_0_b,
  input  logic [6:0]       ha_array_1_b,
  input  logic [6:0]       ha_array_2_b,
  input  logic [6:0]       ha_array_3_b,
  input  logic [8:0]       ha_array_0_t,
  input  logic [8:0]       ha_array_1_t,
  input  logic [8:0]       ha_array_2_t,
  input  logic [8:0]       ha_array_3_t,
  input  logic [7:0]       x,
  input  logic [7:0]       y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] p,
  output logic             ovf,
  output logic [17:0]      err,
  output logic [16:0]      max_abs_err
);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  localparam logic [1:0] LAST_CNT = 2'(4 - ROWS_PER_CYCLE);
  localparam logic [1:0] CNT_STEP = 2'(ROWS_PER_CYCLE);

  if (!(ROWS_PER_CYCLE == 1 || ROWS_PER_CYCLE == 2 || ROWS_PER_CYCLE == 4)) begin : g_bad_rows
    $error("ha_array_accumulator: ROWS_PER_CYCLE must be 1, 2 or 4");
  end
  if (OUT_W < 1 || OUT_W > 18) begin : g_bad_width
    $error("ha_array_accumulator: OUT_W must be between 1 and 18");
  end

  state_t      state;
  logic [1:0]  cnt;
  logic [17:0] acc;
  logic [17:0] acc_next;
  logic [17:0] group_sum;
  logic [1:0]  idx;
  logic [6:0]  b_reg [4];
  logic [8:0]  t_reg [4];
  logic        capture;
  logic        last_group;

  assign in_ready   = (state == IDLE) || (state == DONE && out_ready);
  assign capture    = in_valid && in_ready;
  assign last_group = (cnt == LAST_CNT);
  assign acc_next   = acc + group_sum;
  assign p          = acc[OUT_W-1:0];
  assign ovf        = |(acc >> OUT_W);

  // Weighted sum of the arrays handled this cycle; array k lands at bit 2k
  always_comb begin
    group_sum = '0;
    idx       = '0;
    for (int j = 0; j < ROWS_PER_CYCLE; j++) begin
      idx       = cnt + 2'(j);
      group_sum = group_sum +
                  (({9'd0, t_reg[idx]} + {9'd0, b_reg[idx], 2'b00}) << {idx, 1'b0});
    end
  end

  // Input registers load on every accepted handshake and are wiped by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        b_reg[k] <= '0;
        t_reg[k] <= '0;
      end
    end else if (capture) begin
      b_reg[0] <= ha_array_0_b;
      b_reg[1] <= ha_array_1_b;
      b_reg[2] <= ha_array_2_b;
      b_reg[3] <= ha_array_3_b;
      t_reg[0] <= ha_array_0_t;
      t_reg[1] <= ha_array_1_t;
      t_reg[2] <= ha_array_2_t;
      t_reg[3] <= ha_array_3_t;
    end
  end

  // Control FSM: capture, accumulate group by group, then hold the result
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (capture) begin
            acc   <= '0;
            cnt   <= '0;
            state <= ACC;
          end
        end
        ACC: begin
          acc <= acc_next;
          cnt <= cnt + CNT_STEP;
          if (last_group) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (in_valid) begin
              acc   <= '0;
              cnt   <= '0;
              state <= ACC;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef ERR_MON_EN
  logic [7:0]  x_reg;
  logic [7:0]  y_reg;
  logic [15:0] exact_prod;
  logic [17:0] err_next;
  logic [17:0] abs_next;

  assign exact_prod = x_reg * y_reg;
  assign err_next   = acc_next - {2'b00, exact_prod};
  assign abs_next   = err_next[17] ? (18'd0 - err_next) : err_next;

  // Error monitor: signed error and sticky peak, both updated on entry to DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      x_reg       <= '0;
      y_reg       <= '0;
      err         <= '0;
      max_abs_err <= '0;
    end else begin
      if (capture) begin
        x_reg <= x;
        y_reg <= y;
      end
      if (state == ACC && last_group) begin
        err <= err_next;
        if (abs_next[16:0] > max_abs_err) begin
          max_abs_err <= abs_next[16:0];
        end
      end
    end
  end
`else
  logic unused_xy;

  assign unused_xy   = ^{x, y};
  assign err         = '0;
  assign max_abs_err = '0;
`endif

endmodule
